// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, pushes {pc, instruction} into a prefetch FIFO for decode.
// Latency 1 cycle fetch-to-decode; decode back-pressure fills the FIFO then freezes the PC. Redirect flushes.
// Optional FETCH_BOUND_CHECK_EN adds a FAULT state for fetches beyond MEM_WORDS or past the top of memory.
module fetch_sequencer #(
    parameter int             N         = 32,
    parameter logic [N-1:0]   RESET_PC  = '0,
    parameter int             DEPTH     = 4,
    parameter int             MEM_WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       redirect_valid,
    input  logic [N-1:0]               redirect_pc,
    output logic [N-1:0]               mem_addr,
    input  logic [N-1:0]               mem_data,
    output logic                       ir_valid,
    input  logic                       ir_ready,
    output logic [N-1:0]               ir_data,
    output logic [N-1:0]               ir_pc,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        RESET_PC[1:0] != 2'b00 || MEM_WORDS < 1) begin : g_bad_param
        $error("fetch_sequencer: illegal parameter combination");
    end

`ifdef FETCH_BOUND_CHECK_EN
    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;
    localparam logic [N-1:0] MEM_WORDS_W = N'(MEM_WORDS);
`else
    typedef enum logic [0:0] {IDLE, FETCH} state_t;
`endif

    state_t          state, state_nxt;
    logic [N-1:0]    pc, pc_inc;
    logic            pc_carry;
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [N-1:0]    data_mem [DEPTH];
    logic [N-1:0]    pc_mem   [DEPTH];
    logic            push, pop, room, try_fetch;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign {pc_carry, pc_inc} = {1'b0, pc} + (N+1)'(4);
    assign mem_addr   = pc;
    assign ir_valid   = (count != '0);
    assign ir_data    = data_mem[head];
    assign ir_pc      = pc_mem[head];
    assign fifo_count = count;
    assign pop        = ir_valid & ir_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign room       = (count < CW'(DEPTH)) | pop;

`ifdef FETCH_BOUND_CHECK_EN
    logic wrap_pend;
    logic out_of_range;
    logic target_ok;

    assign out_of_range = ({2'b00, pc[N-1:2]} >= MEM_WORDS_W) | wrap_pend;
    assign target_ok    = {2'b00, redirect_pc[N-1:2]} < MEM_WORDS_W;
    assign fault        = (state == FAULT);
`else
    assign fault        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        try_fetch = 1'b0;
        push      = 1'b0;
        if (redirect_valid) begin
            state_nxt = en ? FETCH : IDLE;
`ifdef FETCH_BOUND_CHECK_EN
            if (state == FAULT && !(en && target_ok)) begin
                state_nxt = IDLE;
            end
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state_nxt = FETCH;
                        try_fetch = 1'b1;
                    end
                end
                FETCH: begin
                    if (!en) begin
                        state_nxt = IDLE;
                    end else begin
                        try_fetch = 1'b1;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
            if (try_fetch && room) begin
`ifdef FETCH_BOUND_CHECK_EN
                if (out_of_range) begin
                    state_nxt = FAULT;
                end else begin
                    push = 1'b1;
                end
`else
                push = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[N-1:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc   <= pc_inc;
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_BOUND_CHECK_EN
    // Remembers that the last push carried out of the top address, so the next fetch faults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_pend <= 1'b0;
        end else if (redirect_valid) begin
            wrap_pend <= 1'b0;
        end else if (push) begin
            wrap_pend <= pc_carry;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = pc_carry;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[tail] <= mem_data;
            pc_mem[tail]   <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory word i holds 32'h1000_0000 + i.
module tb_fetch_sequencer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic [2:0]  fifo_count;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_sequencer #(.N(32), .RESET_PC(32'h0), .DEPTH(4), .MEM_WORDS(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir_data        (ir_data),
        .ir_pc          (ir_pc),
        .fifo_count     (fifo_count),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    assign mem_data = BASE + {2'b00, mem_addr[31:2]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        en             = 1'b1;
        ir_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #12;
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir_data", ir_data, 32'h0);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;

        // Streaming, one instruction per cycle
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stream_valid", 32'(ir_valid), 32'd1);
            chk("stream_pc", ir_pc, 32'(4 * i));
            chk("stream_data", ir_data, BASE + 32'(i));
            chk("stream_count", 32'(fifo_count), 32'd1);
        end
        chk("stream_addr", mem_addr, 32'd24);

        // Queue three entries, then redirect to a misaligned target
        ir_ready = 1'b0;
        step();
        step();
        chk("pre_redir_count", 32'(fifo_count), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        ir_ready       = 1'b1;
        chk("redir_count", 32'(fifo_count), 32'd0);
        chk("redir_valid", 32'(ir_valid), 32'd0);
        chk("redir_addr", mem_addr, 32'h0000_0100);
        step();
        chk("redir_tgt_valid", 32'(ir_valid), 32'd1);
        chk("redir_tgt_pc", ir_pc, 32'h0000_0100);
        chk("redir_tgt_data", ir_data, BASE + 32'd64);
        chk("redir_next_addr", mem_addr, 32'h0000_0104);

        // Asynchronous reset between clock edges
        ir_ready = 1'b0;
        step();
        step();
        chk("pre_arst_count", 32'(fifo_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ir_valid), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_ir_pc", ir_pc, 32'h0);
        rst_n = 1'b1;

        // Back-pressure from reset: FIFO saturates at 4, PC freezes at 16
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("bp_count", 32'(fifo_count), (k < 4) ? 32'(k) : 32'd4);
        end
        chk("bp_addr", mem_addr, 32'd16);
        chk("bp_data_held", ir_data, BASE);
        chk("bp_pc_held", ir_pc, 32'h0);

        // Full FIFO with simultaneous pop and push
        ir_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            chk("full_count", 32'(fifo_count), 32'd4);
            chk("full_pc", ir_pc, 32'(4 * j));
            chk("full_data", ir_data, BASE + 32'(j));
            chk("full_addr", mem_addr, 32'(16 + 4 * j));
        end

        // Fetch disabled: entries drain, nothing pushed
        en = 1'b0;
        step();
        chk("dis_count", 32'(fifo_count), 32'd3);
        chk("dis_addr", mem_addr, 32'd32);
        chk("dis_pc", ir_pc, 32'd20);
        step();
        chk("dis_count2", 32'(fifo_count), 32'd2);
        en = 1'b1;
        step();
        chk("reen_count", 32'(fifo_count), 32'd2);
        chk("reen_addr", mem_addr, 32'd36);

`ifdef FETCH_BOUND_CHECK_EN
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0FFC;
        step();
        redirect_valid = 1'b0;
        chk("bc_redir_count", 32'(fifo_count), 32'd0);
        chk("bc_redir_addr", mem_addr, 32'h0000_0FFC);
        step();
        chk("bc_last_valid", 32'(ir_valid), 32'd1);
        chk("bc_last_data", ir_data, BASE + 32'd1023);
        chk("bc_last_addr", mem_addr, 32'h0000_1000);
        chk("bc_no_fault_yet", 32'(fault), 32'd0);
        step();
        chk("bc_fault", 32'(fault), 32'd1);
        chk("bc_fault_count", 32'(fifo_count), 32'd0);
        chk("bc_fault_addr", mem_addr, 32'h0000_1000);
        step();
        chk("bc_fault_hold", 32'(fault), 32'd1);
        chk("bc_no_push", 32'(ir_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("bc_clear", 32'(fault), 32'd0);
        chk("bc_clear_addr", mem_addr, 32'h0);
        step();
        chk("bc_resume_valid", 32'(ir_valid), 32'd1);
        chk("bc_resume_pc", ir_pc, 32'h0);
        chk("bc_resume_data", ir_data, BASE);
`else
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_redir_addr", mem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_top_pc", ir_pc, 32'hFFFF_FFFC);
        chk("wrap_top_data", ir_data, 32'h4FFF_FFFF);
        chk("wrap_addr", mem_addr, 32'h0);
        chk("wrap_fault", 32'(fault), 32'd0);
        step();
        chk("wrap_next_pc", ir_pc, 32'h0);
        chk("wrap_next_data", ir_data, BASE);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
